// File: rtl/out_reorder.sv
// Traceback output reorder buffer.
//
// The traceback stage produces each block of DEPTH decoded bits newest-first.
// This block buffers them in two ping-pong banks and replays each completed
// block oldest-first. Writing walks a bank from address DEPTH-1 down to 0.
// Reading walks the other bank from 0 up to DEPTH-1, so the bit order flips.
//
// Ports:
//   clk       - single clock, all state on the rising edge
//   rst       - asynchronous active-low reset
//   enable    - 0 synchronously clears all control state and outputs
//   wr_en     - d_in carries a valid decoded bit this cycle
//   d_in      - decoded bit, newest-first within a block
//   d_o       - reordered decoded bit, oldest-first
//   d_o_valid - d_o carries a valid bit this cycle
//   overflow  - sticky: an input bit was dropped because no bank was free
module out_reorder #(
    parameter int unsigned DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic wr_en,
    input  logic d_in,
    output logic d_o,
    output logic d_o_valid,
    output logic overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

    typedef enum logic {StIdle, StRead} state_e;

    // Bank storage carries no reset; the full flags say what is meaningful.
    logic [DEPTH-1:0] mem [2];

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [1:0]      full_q, full_d;
    logic            d_o_d, d_o_valid_d, overflow_d;

    logic rd_last;
    logic writable;
    logic wr_fire;
    logic wr_drop;
    logic wr_last;
    logic rd_start;

    // A full bank still accepts a write on the edge its last bit is read out.
    // The write lands at DEPTH-1, which is the address being read.
    // The read takes the old value, so both can happen on that edge.
    assign rd_last  = (state_q == StRead) && (rd_ptr_q == PtrMax);
    assign writable = !full_q[wr_bank_q] || (rd_last && (rd_bank_q == wr_bank_q));
    assign wr_fire  = enable && wr_en && writable;
    assign wr_drop  = enable && wr_en && !writable;
    assign wr_last  = wr_fire && (wr_ptr_q == '0);
    assign rd_start = (state_q == StIdle) && full_q[rd_bank_q];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank_q][wr_ptr_q] <= d_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        d_o_d       = d_o;
        d_o_valid_d = 1'b0;
        overflow_d  = overflow | wr_drop;

        // Write side.
        if (wr_fire) begin
            if (wr_ptr_q == '0) begin
                wr_ptr_d  = PtrMax;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q - PtrW'(1);
            end
        end

        // Read side.
        unique case (state_q)
            StIdle: begin
                if (rd_start) begin
                    state_d  = StRead;
                    rd_ptr_d = '0;
                end
            end
            StRead: begin
                d_o_d       = mem[rd_bank_q][rd_ptr_q];
                d_o_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PtrW'(1);
                if (rd_last) begin
                    rd_ptr_d  = '0;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = full_q[~rd_bank_q] ? StRead : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear first, then set, so a flag set and a flag clear on
        // different banks in the same cycle both take effect.
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end

        if (!enable) begin
            state_d     = StIdle;
            wr_ptr_d    = PtrMax;
            rd_ptr_d    = '0;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            full_d      = '0;
            d_o_d       = 1'b0;
            d_o_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= PtrMax;
            rd_ptr_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            d_o       <= 1'b0;
            d_o_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            d_o       <= d_o_d;
            d_o_valid <= d_o_valid_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_out_reorder.sv
// Directed bench for out_reorder with DEPTH = 8.
// Edges are numbered from 1 within each scenario.
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point, before the inputs change.
module tb_out_reorder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic wr_en = 1'b0;
    logic d_in = 1'b0;
    logic d_o;
    logic d_o_valid;
    logic overflow;

    int check_cnt = 0;
    int pass_cnt = 0;

    out_reorder #(
        .DEPTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .wr_en    (wr_en),
        .d_in     (d_in),
        .d_o      (d_o),
        .d_o_valid(d_o_valid),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check_cnt++;
        if ({d_o, d_o_valid, overflow} !== 3'b000) begin
            $display("FAIL reset_immediate got %b%b%b exp 000", d_o, d_o_valid, overflow);
        end else begin
            pass_cnt++;
        end
        step();
        step();
        check_cnt++;
        if ({d_o, d_o_valid, overflow} !== 3'b000) begin
            $display("FAIL reset_held got %b%b%b exp 000", d_o, d_o_valid, overflow);
        end else begin
            pass_cnt++;
        end
        rst = 1'b1;
        step();
        check_cnt++;
        if ({d_o, d_o_valid, overflow} !== 3'b000) begin
            $display("FAIL reset_release got %b%b%b exp 000", d_o, d_o_valid, overflow);
        end else begin
            pass_cnt++;
        end
    endtask

    // Single block: the first bit in is the newest bit, so it comes out last.
    task automatic test_single_block();
        logic [7:0] pat;
        logic exp_v;
        pat = 8'h80;
        wr_en = 1'b1;
        d_in = pat[7];
        for (int e = 1; e <= 20; e++) begin
            step();
            exp_v = (e >= 10 && e <= 17);
            check_cnt++;
            if (d_o_valid !== exp_v) begin
                $display("FAIL single_valid e=%0d got %b exp %b", e, d_o_valid, exp_v);
            end else begin
                pass_cnt++;
            end
            if (exp_v) begin
                check_cnt++;
                if (d_o !== pat[e-10]) begin
                    $display("FAIL single_data e=%0d got %b exp %b", e, d_o, pat[e-10]);
                end else begin
                    pass_cnt++;
                end
            end
            if (e < 8) begin
                wr_en = 1'b1;
                d_in = pat[7-e];
            end else begin
                wr_en = 1'b0;
                d_in = 1'b0;
            end
        end
        check_cnt++;
        if (overflow !== 1'b0) begin
            $display("FAIL single_overflow got %b exp 0", overflow);
        end else begin
            pass_cnt++;
        end
    endtask

    // Four blocks written with no gaps; the output must also have no gaps.
    task automatic test_back_to_back();
        logic [7:0] pats [4];
        logic [7:0] cur;
        logic exp_v;
        int j;
        pats[0] = 8'h1D;
        pats[1] = 8'hA6;
        pats[2] = 8'h3C;
        pats[3] = 8'hF0;
        cur = pats[0];
        wr_en = 1'b1;
        d_in = cur[7];
        for (int e = 1; e <= 43; e++) begin
            step();
            exp_v = (e >= 10 && e <= 41);
            check_cnt++;
            if (d_o_valid !== exp_v) begin
                $display("FAIL b2b_valid e=%0d got %b exp %b", e, d_o_valid, exp_v);
            end else begin
                pass_cnt++;
            end
            if (exp_v) begin
                j = e - 10;
                cur = pats[j/8];
                check_cnt++;
                if (d_o !== cur[j%8]) begin
                    $display("FAIL b2b_data e=%0d got %b exp %b", e, d_o, cur[j%8]);
                end else begin
                    pass_cnt++;
                end
            end
            check_cnt++;
            if (overflow !== 1'b0) begin
                $display("FAIL b2b_overflow e=%0d got %b exp 0", e, overflow);
            end else begin
                pass_cnt++;
            end
            if (e < 32) begin
                cur = pats[e/8];
                wr_en = 1'b1;
                d_in = cur[7-(e%8)];
            end else begin
                wr_en = 1'b0;
                d_in = 1'b0;
            end
        end
    endtask

    // Writes only on odd edges; d_in carries junk ones on idle edges.
    task automatic test_paused_write();
        logic [7:0] pat;
        logic exp_v;
        pat = 8'h80;
        wr_en = 1'b1;
        d_in = pat[7];
        for (int e = 1; e <= 26; e++) begin
            step();
            exp_v = (e >= 17 && e <= 24);
            check_cnt++;
            if (d_o_valid !== exp_v) begin
                $display("FAIL pause_valid e=%0d got %b exp %b", e, d_o_valid, exp_v);
            end else begin
                pass_cnt++;
            end
            if (exp_v) begin
                check_cnt++;
                if (d_o !== pat[e-17]) begin
                    $display("FAIL pause_data e=%0d got %b exp %b", e, d_o, pat[e-17]);
                end else begin
                    pass_cnt++;
                end
            end
            if ((e % 2 == 0) && (e + 1 <= 15)) begin
                wr_en = 1'b1;
                d_in = pat[7-(e/2)];
            end else begin
                wr_en = 1'b0;
                d_in = 1'b1;
            end
        end
        check_cnt++;
        if (overflow !== 1'b0) begin
            $display("FAIL pause_overflow got %b exp 0", overflow);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drop enable for one edge partway through a read.
    // The rest of that block must never come out.
    task automatic test_enable_mid_read();
        logic [7:0] pat;
        logic exp_v;
        pat = 8'h5A;
        wr_en = 1'b1;
        d_in = pat[7];
        for (int e = 1; e <= 26; e++) begin
            step();
            exp_v = (e >= 10 && e <= 12);
            check_cnt++;
            if (d_o_valid !== exp_v) begin
                $display("FAIL enmid_valid e=%0d got %b exp %b", e, d_o_valid, exp_v);
            end else begin
                pass_cnt++;
            end
            if (exp_v) begin
                check_cnt++;
                if (d_o !== pat[e-10]) begin
                    $display("FAIL enmid_data e=%0d got %b exp %b", e, d_o, pat[e-10]);
                end else begin
                    pass_cnt++;
                end
            end
            if (e == 13) begin
                check_cnt++;
                if ({d_o, overflow} !== 2'b00) begin
                    $display("FAIL enmid_clear got %b%b exp 00", d_o, overflow);
                end else begin
                    pass_cnt++;
                end
            end
            enable = (e + 1 != 13);
            if (e < 8) begin
                wr_en = 1'b1;
                d_in = pat[7-e];
            end else begin
                wr_en = 1'b0;
                d_in = 1'b0;
            end
        end
        enable = 1'b1;
    endtask

    // Reset during a write that overlaps an ongoing read.
    // The next block must come out clean.
    task automatic test_reset_mid_block();
        logic [7:0] pat;
        logic exp_v;
        wr_en = 1'b1;
        d_in = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 10 || e == 11) begin
                check_cnt++;
                if ({d_o_valid, d_o} !== 2'b11) begin
                    $display("FAIL rstmid_pre e=%0d got %b%b exp 11", e, d_o_valid, d_o);
                end else begin
                    pass_cnt++;
                end
            end
            d_in = (e < 8);
        end
        wr_en = 1'b0;
        rst = 1'b0;
        #1;
        check_cnt++;
        if ({d_o, d_o_valid, overflow} !== 3'b000) begin
            $display("FAIL rstmid_immediate got %b%b%b exp 000", d_o, d_o_valid, overflow);
        end else begin
            pass_cnt++;
        end
        step();
        step();
        rst = 1'b1;
        pat = 8'h96;
        wr_en = 1'b1;
        d_in = pat[7];
        for (int e = 1; e <= 20; e++) begin
            step();
            exp_v = (e >= 10 && e <= 17);
            check_cnt++;
            if (d_o_valid !== exp_v) begin
                $display("FAIL rstmid_valid e=%0d got %b exp %b", e, d_o_valid, exp_v);
            end else begin
                pass_cnt++;
            end
            if (exp_v) begin
                check_cnt++;
                if (d_o !== pat[e-10]) begin
                    $display("FAIL rstmid_data e=%0d got %b exp %b", e, d_o, pat[e-10]);
                end else begin
                    pass_cnt++;
                end
            end
            if (e < 8) begin
                wr_en = 1'b1;
                d_in = pat[7-e];
            end else begin
                wr_en = 1'b0;
                d_in = 1'b0;
            end
        end
    endtask

    // Hold the reader off so both banks fill.
    // The 17th write is dropped and overflow stays set until enable drops.
    task automatic test_overflow();
        int nvalid;
        enable = 1'b0;
        step();
        enable = 1'b1;
        force dut.rd_start = 1'b0;
        wr_en = 1'b1;
        d_in = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            step();
            check_cnt++;
            if (overflow !== (e >= 17)) begin
                $display("FAIL ovf_set e=%0d got %b exp %b", e, overflow, (e >= 17));
            end else begin
                pass_cnt++;
            end
            check_cnt++;
            if (d_o_valid !== 1'b0) begin
                $display("FAIL ovf_stalled_valid e=%0d got %b exp 0", e, d_o_valid);
            end else begin
                pass_cnt++;
            end
        end
        wr_en = 1'b0;
        release dut.rd_start;
        nvalid = 0;
        for (int e = 18; e <= 40; e++) begin
            step();
            if (d_o_valid === 1'b1) begin
                nvalid++;
                check_cnt++;
                if (d_o !== 1'b1) begin
                    $display("FAIL ovf_data e=%0d got %b exp 1", e, d_o);
                end else begin
                    pass_cnt++;
                end
            end
            check_cnt++;
            if (overflow !== 1'b1) begin
                $display("FAIL ovf_sticky e=%0d got %b exp 1", e, overflow);
            end else begin
                pass_cnt++;
            end
        end
        check_cnt++;
        if (nvalid != 16) begin
            $display("FAIL ovf_valid_count got %0d exp 16", nvalid);
        end else begin
            pass_cnt++;
        end
        enable = 1'b0;
        step();
        check_cnt++;
        if ({overflow, d_o_valid, d_o} !== 3'b000) begin
            $display("FAIL ovf_clear got %b%b%b exp 000", overflow, d_o_valid, d_o);
        end else begin
            pass_cnt++;
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_paused_write();
        test_enable_mid_read();
        test_reset_mid_block();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/out_reorder.md
OUT_REORDER -- requirements
Module: out_reorder

Interface
REQ-001 SHALL provide parameter DEPTH, default 64, meaning decoded bits per traceback block (power of two, >=4).
REQ-002 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL provide port enable  input  1  block enable; 0 = synchronous clear of all state.
REQ-005 SHALL provide port wr_en  input  1  write strobe from traceback stage; d_in valid this cycle.
REQ-006 SHALL provide port d_in  input  1  decoded bit, arriving newest-first (time-reversed) within a block.
REQ-007 SHALL provide port d_o  output  1  decoded bit, oldest-first (correct order).
REQ-008 SHALL provide port d_o_valid  output  1  d_o carries a valid bit this cycle.
REQ-009 SHALL provide port overflow  output  1  sticky flag: an input bit was dropped.

Function
REQ-010 SHALL hold two DEPTH x 1 banks (ping-pong), a write bank select, a read bank select, one full flag per bank.
REQ-011 SHALL, on each edge with enable=1, wr_en=1 and the write bank writable, store d_in at wr_ptr and decrement wr_ptr.
REQ-012 SHALL start wr_ptr at DEPTH-1 per block; on the write to address 0, set that bank's full flag, toggle write bank, reload wr_ptr to DEPTH-1.
REQ-013 SHALL treat wr_en=0 mid-block as a pause: wr_ptr and bank held, block resumes on next wr_en=1.
REQ-014 SHALL treat the write bank as writable if its full flag is 0, or if the read FSM reads its last address (DEPTH-1) of that bank on the same edge.
REQ-015 SHALL, on wr_en=1 with write bank not writable, drop d_in, leave wr_ptr unchanged, set overflow=1.
REQ-016 SHALL implement read FSM states IDLE and READ; rd_ptr counts 0..DEPTH-1.
REQ-017 SHALL, in IDLE with full[rd_bank]=1, go to READ with rd_ptr=0 on the next edge; d_o_valid=0 in IDLE.
REQ-018 SHALL, in READ each edge, register d_o <= bank[rd_bank][rd_ptr], d_o_valid <= 1, rd_ptr++.
REQ-019 SHALL, on the edge reading rd_ptr=DEPTH-1, clear full[rd_bank] and toggle rd_bank; next state READ with rd_ptr=0 if other bank full at that edge, else IDLE.
REQ-020 SHALL give latency: first d_o_valid=1 on the 2nd edge after the edge writing address 0; then DEPTH consecutive valid cycles per block.
REQ-021 SHALL sustain continuous wr_en=1 with no overflow (back-to-back blocks, gapless d_o_valid after the first block).
REQ-022 SHALL, on simultaneous full-flag set (write) and clear (read) of different banks, apply both.
REQ-023 SHALL, with enable=0, on the next edge clear pointers, bank selects, full flags, FSM to IDLE, d_o=0, d_o_valid=0, overflow=0; bank contents need not clear.
REQ-024 SHALL keep overflow=1 until reset or enable=0.

Reset
REQ-025 SHALL, with rst=0, immediately force d_o=0, d_o_valid=0, overflow=0, FSM IDLE, full flags 0, both bank selects to bank 0, wr_ptr=DEPTH-1, rd_ptr=0.
REQ-026 SHALL, on rst assertion mid-block or mid-read, discard all partial data; first block after release starts at wr_ptr=DEPTH-1 bank 0.

Verification (DEPTH=8)
REQ-027 SHALL cover: enable=1, wr_en=1 for 8 cycles with d_in=1,0,0,0,0,0,0,0 -> 2 edges after 8th write, d_o=0,0,0,0,0,0,0,1 with d_o_valid=1 for exactly 8 cycles, overflow=0.
REQ-028 SHALL cover: wr_en=1 continuously for 32 cycles, d_in = reversed 4-block ramp -> d_o_valid high 32 consecutive cycles, bits in original order, overflow=0.
REQ-029 SHALL cover: wr_en toggled 1,0,1,0 for a block (16 cycles for 8 bits) -> same d_o sequence as gapless case, no overflow.
REQ-030 SHALL cover: hold FSM by forcing 3 blocks with one read blocked by enable pattern is not allowed; instead write 8 bits, deassert then reassert enable mid-read -> d_o_valid drops to 0 next edge, no further valid bits, overflow=0.
REQ-031 SHALL cover: rst pulsed low 3 cycles into a write block -> outputs 0 immediately; next 8 writes produce one correctly ordered block 2 edges after completion.
REQ-032 SHALL cover: force overflow via stuck read (bench holds design with both banks full by back-pressure-free burst after enable glitch) -> check overflow=1 on first dropped bit and remains 1 until enable=0.
